access_timing_ctrl: RTL

//  Sequencer for the master-clock CPU speed counter. Decodes each CPU access to a
//  mem_speed_type and owns the MEMSEL ($420D) fast-ROM bit (speed_change/new_speed).

---
 rtl/access_timing_ctrl_pkg.sv | 34 +++
 rtl/access_timing_ctrl_if.sv | 32 +++
 rtl/access_timing_ctrl_decode.sv | 30 +++
 rtl/access_timing_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/access_timing_ctrl_pkg.sv
// Shared types and address constants for the CPU access timing sequencer.
// Imported by the decoder, the bus interface and the controller top.
package access_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    SPEED_FAST,
    SPEED_SLOW,
    SPEED_XSLOW,
    SPEED_VAR
  } mem_speed_type;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_REFRESH,
    ST_DMA_SYNC,
    ST_DMA,
    ST_REFRESH_DMA,
    ST_RESYNC
  } atc_state_t;

  localparam logic [15:0] MEMSEL_ADDR   = 16'h420D;
  // Inclusive upper bounds of the system-bank offset regions.
  localparam logic [15:0] SLOW_LO_END   = 16'h1FFF;
  localparam logic [15:0] FAST_LO_END   = 16'h3FFF;
  localparam logic [15:0] XSLOW_END     = 16'h41FF;
  localparam logic [15:0] FAST_HI_END   = 16'h5FFF;
  localparam logic [15:0] SLOW_HI_END   = 16'h7FFF;

  // Banks 00-3F and 80-BF carry the system map; bit 6 clear identifies both.
  function automatic logic is_sys_bank(input logic [7:0] bank);
    return !bank[6];
  endfunction

endpackage

// File: rtl/access_timing_ctrl_if.sv
// CPU bus and DMA handshake bundle between the CPU core, DMA unit and the
// access timing controller.
interface access_timing_ctrl_if;
  import access_timing_ctrl_pkg::*;

  logic          cpu_en;
  logic [23:0]   cpu_addr;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [7:0]    cpu_wdata;
  logic          mem_access;
  mem_speed_type mem_speed;
  logic          speed_change;
  logic          new_speed;
  logic          dma_req;
  logic          dma_step;
  logic          dma_done;
  logic          dma_grant;

  modport slave (
    input  cpu_en, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    input  dma_req, dma_step, dma_done,
    output mem_access, mem_speed, speed_change, new_speed, dma_grant
  );

  modport master (
    output cpu_en, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    output dma_req, dma_step, dma_done,
    input  mem_access, mem_speed, speed_change, new_speed, dma_grant
  );

endinterface

// File: rtl/access_timing_ctrl_decode.sv
// Combinational address-to-speed decode for the current CPU access.
// VAR regions are resolved by the speed counter using the MEMSEL bit.
module mem_speed_decode
  import access_timing_ctrl_pkg::*;
(
  input  logic [23:0]   addr,
  output mem_speed_type speed
);

  logic [7:0]  bank;
  logic [15:0] off;

  assign bank = addr[23:16];
  assign off  = addr[15:0];

  always_comb begin
    speed = SPEED_SLOW;
    if (is_sys_bank(bank)) begin
      if (off <= SLOW_LO_END)      speed = SPEED_SLOW;
      else if (off <= FAST_LO_END) speed = SPEED_FAST;
      else if (off <= XSLOW_END)   speed = SPEED_XSLOW;
      else if (off <= FAST_HI_END) speed = SPEED_FAST;
      else if (off <= SLOW_HI_END) speed = SPEED_SLOW;
      else                         speed = bank[7] ? SPEED_VAR : SPEED_SLOW;
    end else if (bank[7]) begin
      speed = SPEED_VAR;
    end
  end

endmodule

// File: rtl/access_timing_ctrl.sv
// Stall sequencer for the CPU speed counter: DRAM refresh, aligned DMA
// takeover and the MEMSEL fast-ROM bit.
module access_timing_ctrl
  import access_timing_ctrl_pkg::*;
#(
  parameter int REFRESH_CLKS = 40,
  parameter int DMA_ALIGN    = 8,
  parameter int RESYNC_CLKS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  access_timing_ctrl_if.slave   bus,
  input  logic                  refresh_trig,
  output logic                  stop,
  output logic                  refresh_active,
  output logic                  memsel
);

  localparam int CTR_MAX = (REFRESH_CLKS > RESYNC_CLKS) ? REFRESH_CLKS : RESYNC_CLKS;
  localparam int CTR_W   = $clog2(CTR_MAX);
  localparam int ALIGN_W = $clog2(DMA_ALIGN);

  atc_state_t         state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [ALIGN_W-1:0] align_q, align_d;
  logic               refresh_pend_q, refresh_pend_d;
  logic               memsel_q, memsel_d;
  logic               enter_refresh;
  logic               memsel_hit;

  mem_speed_decode u_decode (
    .addr  (bus.cpu_addr),
    .speed (bus.mem_speed)
  );

  assign memsel_hit = is_sys_bank(bus.cpu_addr[23:16]) &&
                      (bus.cpu_addr[15:0] == MEMSEL_ADDR) &&
                      bus.cpu_wr && bus.cpu_en;

  assign bus.mem_access   = bus.cpu_rd | bus.cpu_wr;
  assign bus.speed_change = memsel_hit;
  assign bus.new_speed    = memsel_hit & bus.cpu_wdata[0];

  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    enter_refresh = 1'b0;
    align_d       = align_q + ALIGN_W'(1);
    memsel_d      = memsel_hit ? bus.cpu_wdata[0] : memsel_q;

    case (state_q)
      ST_RUN: begin
        // Transitions only at a CPU-cycle boundary so the cycle in flight completes.
        if (bus.cpu_en) begin
          if (refresh_pend_q) begin
            state_d       = ST_REFRESH;
            ctr_d         = CTR_W'(REFRESH_CLKS - 1);
            enter_refresh = 1'b1;
          end else if (bus.dma_req) begin
            state_d = ST_DMA_SYNC;
          end
        end
      end
      ST_REFRESH: begin
        if (ctr_q == '0) state_d = ST_RUN;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      ST_DMA_SYNC: begin
        if (!bus.dma_req)                            state_d = ST_RUN;
        else if (align_q == ALIGN_W'(DMA_ALIGN - 1)) state_d = ST_DMA;
      end
      ST_DMA: begin
        if (bus.dma_done) begin
          state_d = ST_RESYNC;
          ctr_d   = CTR_W'(RESYNC_CLKS - 1);
        end else if (bus.dma_step && refresh_pend_q) begin
          state_d       = ST_REFRESH_DMA;
          ctr_d         = CTR_W'(REFRESH_CLKS - 1);
          enter_refresh = 1'b1;
        end
      end
      ST_REFRESH_DMA: begin
        if (ctr_q == '0) state_d = ST_DMA;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      ST_RESYNC: begin
        if (ctr_q == '0) state_d = ST_RUN;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      default: state_d = ST_RUN;
    endcase

    // A trigger landing on the clock that consumes the pending request is dropped.
    refresh_pend_d = enter_refresh ? 1'b0 : (refresh_pend_q | refresh_trig);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      ctr_q          <= '0;
      align_q        <= '0;
      refresh_pend_q <= 1'b0;
      memsel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      align_q        <= align_d;
      refresh_pend_q <= refresh_pend_d;
      memsel_q       <= memsel_d;
    end
  end

  assign stop           = (state_q != ST_RUN);
  assign bus.dma_grant  = (state_q == ST_DMA);
  assign refresh_active = (state_q == ST_REFRESH) || (state_q == ST_REFRESH_DMA);
  assign memsel         = memsel_q;

endmodule
